// File: rtl/mm_ctrl_pkg.sv
// Shared state encodings and default sizing for the matrix-multiplier front panel.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_SHOW  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam int DIM_DEF          = 4;
  localparam int DEBOUNCE_CYC_DEF = 16;
  localparam int TIMEOUT_CYC_DEF  = 1024;

  // Result address width; a 1x1 result still needs a one-bit address.
  function automatic int addr_w(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

endpackage

// File: rtl/mm_button_sequencer_if.sv
// Board-side buttons, multiplier handshake and display read port of the panel controller.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface mm_button_sequencer_if
  import mm_ctrl_pkg::*;
#(
  parameter int DIM = DIM_DEF
);
  localparam int ADDR_W = addr_w(DIM);

  logic              btn_start;
  logic              btn_next;
  logic              btn_clear;
  logic              mm_done;
  logic              mm_start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              fault;
  logic [1:0]        state_o;

  // The sequencer side.
  modport master (
    input  btn_start, btn_next, btn_clear, mm_done,
    output mm_start, rd_en, rd_addr, busy, fault, state_o
  );

  // The board / multiplier side.
  modport slave (
    output btn_start, btn_next, btn_clear, mm_done,
    input  mm_start, rd_en, rd_addr, busy, fault, state_o
  );

endinterface

// File: rtl/btn_pulse.sv
// Raw push-button to single-cycle press pulse: 2-flop synchroniser, debounce, rising-edge one-shot.
// Latency: pulse registered 2 + DEBOUNCE_CYC cycles after the raw level settles high.
// Backpressure: none; one pulse per accepted press, releases and short glitches produce nothing.
module btn_pulse
  import mm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync0;
  logic             sync1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
    end
  end

  // Count consecutive samples that differ from the accepted level; any return to the
  // accepted level restarts the count, so only an unbroken run of DEBOUNCE_CYC is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync1;
        pulse <= sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_button_sequencer.sv
// Front-panel controller: launches the multiplier, times out a hung run, then steps the display read address.
// Latency: mm_start / rd_en are registered one cycle after the triggering press pulse or mm_done.
// Backpressure: none; presses that land in a state which ignores them are dropped, never queued.
module mm_button_sequencer
  import mm_ctrl_pkg::*;
#(
  parameter int DIM          = DIM_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  mm_button_sequencer_if.master io
);
  localparam int                ADDR_W    = addr_w(DIM);
  localparam int                TMR_W     = $clog2(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DIM * DIM - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  logic start_p;
  logic next_p;
  logic clear_p;

  state_t            state_q,    state_d;
  logic [TMR_W-1:0]  timer_q,    timer_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              mm_start_q, mm_start_d;
  logic              rd_en_q,    rd_en_d;

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (io.btn_start),
    .pulse (start_p)
  );

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
    .clk   (clk),
    .reset (reset),
    .btn   (io.btn_next),
    .pulse (next_p)
  );

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (io.btn_clear),
    .pulse (clear_p)
  );

  // State, run timer, read address and the two registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      addr_q     <= '0;
      mm_start_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      mm_start_q <= mm_start_d;
      rd_en_q    <= rd_en_d;
    end
  end

  // Next state and strobes; within a state clear beats start beats next.
  // The timer sits at zero outside RUN so every run starts counting from zero.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    addr_d     = addr_q;
    mm_start_d = 1'b0;
    rd_en_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          mm_start_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        // No buttons are honoured here: a run cannot be aborted, only completed or timed out.
        timer_d = timer_q + 1'b1;
        if (io.mm_done) begin
          state_d = ST_SHOW;
          addr_d  = '0;
          rd_en_d = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_SHOW: begin
        if (clear_p) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end else if (start_p) begin
          mm_start_d = 1'b1;
          state_d    = ST_RUN;
        end else if (next_p) begin
          addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          rd_en_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (clear_p) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  assign io.mm_start = mm_start_q;
  assign io.rd_en    = rd_en_q;
  assign io.rd_addr  = addr_q;
  assign io.busy     = (state_q == ST_RUN);
  assign io.fault    = (state_q == ST_FAULT);
  assign io.state_o  = state_q;

endmodule
